// File: rtl/obstacle_spawner.sv
// Obstacle table writer: advances every active obstacle toward the player on
// each frame tick, retires the ones that pass, and spawns new ones into free
// slots with a pseudo-random lane taken from a free-running Galois LFSR.

package data_pkg;

    // One entry of the obstacle table shared with the collision logic.
    typedef struct packed {
        logic        active;
        logic [1:0]  lane;
        logic [10:0] position;
    } obstacle;

endpackage

module obstacle_spawner #(
    parameter logic [10:0] SPAWN_POS  = 11'd1200,
    parameter logic [4:0]  SPAWN_PROB = 5'd16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                     system_clock_in,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic                     enable,
    input  logic                     restart,
    input  logic [3:0]               speed,
    input  logic [7:0]               spawn_interval,
    output data_pkg::obstacle [9:0]  obstacles,
    output logic                     spawned,
    output logic                     spawn_dropped,
    output logic [3:0]               active_count
);

    import data_pkg::*;

    localparam int          NUM_SLOTS = 10;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [15:0]          lfsr;
    logic [15:0]          lfsr_next;
    logic [7:0]           gap;
    logic [7:0]           gap_next;

    logic                 update;
    logic                 due;
    logic                 prob_ok;
    logic                 attempt;
    logic                 free_found;
    logic [3:0]           free_idx;
    logic [1:0]           spawn_lane;
    logic                 do_spawn;
    logic                 do_drop;
    obstacle [9:0]        table_next;
    logic [3:0]           count_next;

    // Galois step: shift right, fold the tap mask back in when a one drops out.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ LFSR_TAPS;
        end
    end

    // Spawn decision: due/probability gating and lowest free slot before retirements.
    always_comb begin
        update     = tick & enable;
        due        = (gap >= spawn_interval);
        prob_ok    = ({1'b0, lfsr[7:4]} < SPAWN_PROB);
        attempt    = update & due & prob_ok;
        free_found = 1'b0;
        free_idx   = 4'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!obstacles[i].active) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
        do_spawn   = attempt & free_found;
        do_drop    = attempt & ~free_found;
        // Lane 3 does not exist on the playfield; fold it onto the middle lane.
        spawn_lane = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];
    end

    // Next table: move and retire active slots, then drop the new obstacle in.
    always_comb begin
        table_next = obstacles;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (obstacles[i].active && (speed != 4'd0)) begin
                if (obstacles[i].position <= {7'd0, speed}) begin
                    table_next[i].active   = 1'b0;
                    table_next[i].position = 11'd0;
                end else begin
                    table_next[i].position = obstacles[i].position - {7'd0, speed};
                end
            end
        end
        // The target slot was inactive, so the move step above left it alone;
        // the fresh obstacle therefore does not advance on its spawn tick.
        if (do_spawn) begin
            table_next[free_idx].active   = 1'b1;
            table_next[free_idx].lane     = spawn_lane;
            table_next[free_idx].position = SPAWN_POS;
        end
    end

    // Population count of the updated table and the next gap counter value.
    always_comb begin
        count_next = 4'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_next = count_next + {3'd0, table_next[i].active};
        end
        if (do_spawn) begin
            gap_next = 8'd0;
        end else if (gap < spawn_interval) begin
            gap_next = gap + 8'd1;
        end else begin
            gap_next = gap;
        end
    end

    // LFSR runs every cycle; restart deliberately leaves it alone.
    always_ff @(posedge system_clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Table, gap counter and status outputs; only an enabled tick changes them.
    always_ff @(posedge system_clock_in or negedge reset_n) begin
        if (!reset_n) begin
            obstacles     <= '0;
            gap           <= 8'd0;
            spawned       <= 1'b0;
            spawn_dropped <= 1'b0;
            active_count  <= 4'd0;
        end else if (restart) begin
            obstacles     <= '0;
            gap           <= 8'd0;
            spawned       <= 1'b0;
            spawn_dropped <= 1'b0;
            active_count  <= 4'd0;
        end else if (update) begin
            obstacles     <= table_next;
            gap           <= gap_next;
            spawned       <= do_spawn;
            spawn_dropped <= do_drop;
            active_count  <= count_next;
        end else begin
            spawned       <= 1'b0;
            spawn_dropped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: spawn timing, retirement boundary,
// full table, retire-and-spawn, lane mapping, freeze, restart, reset, and a
// second instance with reduced spawn probability and a zero seed.

module tb_obstacle_spawner;

    import data_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          enable = 1'b1;
    logic          restart = 1'b0;
    logic [3:0]    speed = 4'd0;
    logic [7:0]    interval = 8'd0;

    obstacle [9:0] obs;
    obstacle [9:0] obs2;
    logic          spawned, dropped, spawned2, dropped2;
    logic [3:0]    cnt, cnt2;

    int checks = 0;
    int errors = 0;

    logic [15:0]   m_lfsr;
    logic [15:0]   tick_lfsr;
    logic [1:0]    lane0;
    int            exp_cnt2;
    logic          p_ok;

    always #5 clk = ~clk;

    obstacle_spawner dut (
        .system_clock_in(clk), .reset_n(rst_n), .tick(tick), .enable(enable),
        .restart(restart), .speed(speed), .spawn_interval(interval),
        .obstacles(obs), .spawned(spawned), .spawn_dropped(dropped),
        .active_count(cnt)
    );

    obstacle_spawner #(.SPAWN_PROB(5'd8), .SEED(16'h0000)) dut2 (
        .system_clock_in(clk), .reset_n(rst_n), .tick(tick), .enable(enable),
        .restart(restart), .speed(speed), .spawn_interval(interval),
        .obstacles(obs2), .spawned(spawned2), .spawn_dropped(dropped2),
        .active_count(cnt2)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [1:0] map_lane(input logic [1:0] v);
        return (v == 2'd3) ? 2'd1 : v;
    endfunction

    // Reference LFSR, free-running like the DUT's.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    // LFSR value the DUT sees on the edge that samples a tick.
    always @(posedge clk) begin
        if (tick) tick_lfsr <= m_lfsr;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic chk_slot(input string tag, input int idx, input logic act,
                            input logic [1:0] lane, input logic [10:0] pos);
        chk({tag, ".active"}, 32'(obs[idx].active), 32'(act));
        chk({tag, ".lane"}, 32'(obs[idx].lane), 32'(lane));
        chk({tag, ".position"}, 32'(obs[idx].position), 32'(pos));
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        // Reset state while reset_n is held low.
        #12;
        chk("reset_table", 32'(obs === '0), 32'd1);
        chk("reset_count", 32'(cnt), 32'd0);
        chk("reset_spawned", 32'(spawned), 32'd0);
        chk("reset_dropped", 32'(dropped), 32'd0);
        chk("reset_lfsr", 32'(dut.lfsr), 32'hACE1);
        chk("reset_lfsr_zero_seed", 32'(dut2.lfsr), 32'hACE1);
        @(negedge clk);
        rst_n = 1'b1;

        // Spawn timing: interval 3, speed 2, tick every 4 cycles.
        interval = 8'd3;
        speed    = 4'd2;
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            chk("timing_no_spawn", 32'(spawned), 32'd0);
            chk("timing_count0", 32'(cnt), 32'd0);
            repeat (2) @(negedge clk);
        end
        do_tick();
        chk("tick4_spawned", 32'(spawned), 32'd1);
        chk_slot("tick4_slot0", 0, 1'b1, map_lane(tick_lfsr[1:0]), 11'd1200);
        lane0 = map_lane(tick_lfsr[1:0]);
        chk("tick4_count", 32'(cnt), 32'd1);
        @(negedge clk);
        chk("spawn_pulse_width", 32'(spawned), 32'd0);
        @(negedge clk);
        do_tick();
        chk_slot("tick5_slot0", 0, 1'b1, lane0, 11'd1198);
        chk("tick5_spawned", 32'(spawned), 32'd0);
        for (int t = 6; t <= 7; t++) begin
            repeat (2) @(negedge clk);
            do_tick();
            chk("tick67_no_spawn", 32'(spawned), 32'd0);
        end
        repeat (2) @(negedge clk);
        do_tick();
        chk("tick8_spawned", 32'(spawned), 32'd1);
        chk_slot("tick8_slot1", 1, 1'b1, map_lane(tick_lfsr[1:0]), 11'd1200);
        chk("tick8_slot0_pos", 32'(obs[0].position), 32'd1192);
        chk("tick8_count", 32'(cnt), 32'd2);

        // Retirement boundary: slot 0 at 3, slot 1 at 4, speed 3.
        do_restart();
        interval = 8'd0;
        speed    = 4'd1;
        do_tick();
        lane0 = map_lane(tick_lfsr[1:0]);
        do_tick();
        chk("ret_two_spawned", 32'(cnt), 32'd2);
        interval = 8'd255;
        speed    = 4'd15;
        repeat (79) do_tick();
        chk("ret_pre_s0", 32'(obs[0].position), 32'd14);
        chk("ret_pre_s1", 32'(obs[1].position), 32'd15);
        speed = 4'd11;
        do_tick();
        chk("ret_s0_at3", 32'(obs[0].position), 32'd3);
        chk("ret_s1_at4", 32'(obs[1].position), 32'd4);
        chk("ret_count2", 32'(cnt), 32'd2);
        speed = 4'd3;
        do_tick();
        chk_slot("ret_s0_retired", 0, 1'b0, lane0, 11'd0);
        chk("ret_s1_active", 32'(obs[1].active), 32'd1);
        chk("ret_s1_pos1", 32'(obs[1].position), 32'd1);
        chk("ret_count1", 32'(cnt), 32'd1);
        do_tick();
        chk("ret_s1_retired", 32'(obs[1].active), 32'd0);
        chk("ret_count0", 32'(cnt), 32'd0);

        // Table full: interval 0, speed 0, 11 ticks.
        do_restart();
        interval = 8'd0;
        speed    = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            chk("full_spawned", 32'(spawned), 32'd1);
            chk("full_slot_active", 32'(obs[k-1].active), 32'd1);
            chk("full_count", 32'(cnt), 32'(k));
        end
        do_tick();
        chk("full_dropped", 32'(dropped), 32'd1);
        chk("full_no_spawn", 32'(spawned), 32'd0);
        chk("full_count10", 32'(cnt), 32'd10);

        // Retire and spawn on the same tick with a full table.
        do_restart();
        do_tick();
        interval = 8'd255;
        speed    = 4'd15;
        repeat (79) do_tick();
        chk("rs_s0_at15", 32'(obs[0].position), 32'd15);
        interval = 8'd0;
        speed    = 4'd0;
        repeat (9) do_tick();
        chk("rs_full", 32'(cnt), 32'd10);
        speed = 4'd15;
        do_tick();
        chk("rs_dropped", 32'(dropped), 32'd1);
        chk("rs_no_spawn", 32'(spawned), 32'd0);
        chk("rs_s0_retired", 32'(obs[0].active), 32'd0);
        chk("rs_s1_moved", 32'(obs[1].position), 32'd1185);
        chk("rs_count9", 32'(cnt), 32'd9);
        speed = 4'd0;
        do_tick();
        chk("rs_respawn", 32'(spawned), 32'd1);
        chk_slot("rs_slot0", 0, 1'b1, map_lane(tick_lfsr[1:0]), 11'd1200);
        chk("rs_count10", 32'(cnt), 32'd10);

        // Lane mapping over 200 spawns.
        for (int k = 0; k < 200; k++) begin
            if (k % 10 == 0) do_restart();
            do_tick();
            chk("lane_spawned", 32'(spawned), 32'd1);
            chk("lane_value", 32'(obs[k % 10].lane), 32'(map_lane(tick_lfsr[1:0])));
            chk("lane_not3", 32'(obs[k % 10].lane == 2'd3), 32'd0);
        end

        // enable low freezes the table.
        enable = 1'b0;
        speed  = 4'd5;
        repeat (3) begin
            do_tick();
            chk("freeze_spawned", 32'(spawned), 32'd0);
            chk("freeze_dropped", 32'(dropped), 32'd0);
            chk("freeze_count", 32'(cnt), 32'd10);
            chk("freeze_s0", 32'(obs[0].position), 32'd1200);
            chk("freeze_s9", 32'(obs[9].position), 32'd1200);
        end
        enable = 1'b1;

        // Restart together with tick.
        @(negedge clk);
        restart = 1'b1;
        tick    = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        tick    = 1'b0;
        chk("restart_table", 32'(obs === '0), 32'd1);
        chk("restart_count", 32'(cnt), 32'd0);
        chk("restart_spawned", 32'(spawned), 32'd0);
        chk("restart_lfsr_runs", 32'(dut.lfsr), 32'(m_lfsr));

        // Reduced spawn probability on the zero-seed instance.
        speed    = 4'd0;
        interval = 8'd0;
        exp_cnt2 = 0;
        for (int k = 0; k < 12; k++) begin
            do_tick();
            p_ok = (tick_lfsr[7:4] < 4'd8);
            chk("prob_spawned", 32'(spawned2), 32'(p_ok && exp_cnt2 < 10));
            chk("prob_dropped", 32'(dropped2), 32'(p_ok && exp_cnt2 == 10));
            if (p_ok && exp_cnt2 < 10) exp_cnt2++;
            chk("prob_count", 32'(cnt2), 32'(exp_cnt2));
        end

        // Asynchronous reset mid-run.
        do_tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_table", 32'(obs === '0), 32'd1);
        chk("async_count", 32'(cnt), 32'd0);
        chk("async_spawned", 32'(spawned), 32'd0);
        chk("async_dropped", 32'(dropped), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_lfsr", 32'(dut.lfsr), 32'hACE1);
        chk("release_lfsr2", 32'(dut2.lfsr), 32'hACE1);
        repeat (3) @(negedge clk);
        chk("lfsr_track", 32'(dut.lfsr), 32'(m_lfsr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
